// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing one unified-L2 request port between the CPU L1 and the miniGPU L1.
// Define L2_ARB_PERF_CNT_EN to add grant/stall performance counters with a perf_clr port.
module l2_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic                  cpu_req_we,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
    output logic                  cpu_rsp_err,
    input  logic                  gpu_req_valid,
    output logic                  gpu_req_ready,
    input  logic [ADDR_WIDTH-1:0] gpu_req_addr,
    input  logic                  gpu_req_we,
    input  logic [DATA_WIDTH-1:0] gpu_req_wdata,
    output logic                  gpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] gpu_rsp_rdata,
    output logic                  gpu_rsp_err,
    output logic                  l2_req_valid,
    output logic [ADDR_WIDTH-1:0] l2_req_addr,
    output logic                  l2_req_we,
    output logic [DATA_WIDTH-1:0] l2_req_wdata,
    input  logic                  l2_rsp_valid,
    input  logic [DATA_WIDTH-1:0] l2_rsp_rdata
`ifdef L2_ARB_PERF_CNT_EN
    ,
    input  logic                  perf_clr,
    output logic [31:0]           cpu_grant_cnt,
    output logic [31:0]           gpu_grant_cnt,
    output logic [31:0]           cpu_stall_cnt,
    output logic [31:0]           gpu_stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t        state;
    req_t          req_q;
    logic          owner;       // 1 = GPU owns the in-flight transaction
    logic          last_grant;  // 1 = GPU was granted last
    logic          l2_vld_q;
    logic [CW-1:0] to_cnt;

    logic grant_cpu, grant_gpu, accept, rsp_hit, to_fire, rsp_fire;

    // On a tie the requester that did not win last time goes first.
    assign grant_cpu     = cpu_req_valid && (!gpu_req_valid || last_grant);
    assign grant_gpu     = gpu_req_valid && !grant_cpu;
    assign cpu_req_ready = (state == IDLE) && grant_cpu;
    assign gpu_req_ready = (state == IDLE) && grant_gpu;
    assign accept        = cpu_req_ready || gpu_req_ready;

    // Responses are only honoured in WAIT, so stale L2 strobes never leak out.
    assign rsp_hit = (state == WAIT) && l2_rsp_valid;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            assign to_fire = (state == WAIT) && !l2_rsp_valid && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wdog
            assign to_fire = 1'b0;
        end
    endgenerate

    assign rsp_fire = rsp_hit || to_fire;

    assign cpu_rsp_valid = rsp_fire && !owner;
    assign gpu_rsp_valid = rsp_fire && owner;
    assign cpu_rsp_rdata = (rsp_hit && !owner) ? l2_rsp_rdata : '0;
    assign gpu_rsp_rdata = (rsp_hit && owner) ? l2_rsp_rdata : '0;
    assign cpu_rsp_err   = to_fire && !owner;
    assign gpu_rsp_err   = to_fire && owner;

    assign l2_req_valid = l2_vld_q;
    assign l2_req_addr  = req_q.addr;
    assign l2_req_we    = req_q.we;
    assign l2_req_wdata = req_q.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            l2_vld_q   <= 1'b0;
            to_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q      <= cpu_req_ready ? req_t'{cpu_req_addr, cpu_req_we, cpu_req_wdata}
                                                    : req_t'{gpu_req_addr, gpu_req_we, gpu_req_wdata};
                        owner      <= gpu_req_ready;
                        last_grant <= gpu_req_ready;
                        l2_vld_q   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    l2_vld_q <= 1'b0;
                    to_cnt   <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (rsp_fire) state <= IDLE;
                    else          to_cnt <= to_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L2_ARB_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
        return (en && (c != 32'hFFFF_FFFF)) ? c + 32'd1 : c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            cpu_grant_cnt <= '0;
            gpu_grant_cnt <= '0;
            cpu_stall_cnt <= '0;
            gpu_stall_cnt <= '0;
        end else begin
            cpu_grant_cnt <= sat_inc(cpu_grant_cnt, cpu_req_ready);
            gpu_grant_cnt <= sat_inc(gpu_grant_cnt, gpu_req_ready);
            cpu_stall_cnt <= sat_inc(cpu_stall_cnt, cpu_req_valid && !cpu_req_ready);
            gpu_stall_cnt <= sat_inc(gpu_stall_cnt, gpu_req_valid && !gpu_req_ready);
        end
    end
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Scoreboard bench for l2_req_arbiter: L2 model with programmable latency, response monitor.
module tb_l2_req_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_we = 1'b0;
    logic [31:0] cpu_req_addr = '0, cpu_req_wdata = '0;
    logic        cpu_rsp_valid, cpu_rsp_err;
    logic [31:0] cpu_rsp_rdata;
    logic        gpu_req_valid = 1'b0, gpu_req_ready, gpu_req_we = 1'b0;
    logic [31:0] gpu_req_addr = '0, gpu_req_wdata = '0;
    logic        gpu_rsp_valid, gpu_rsp_err;
    logic [31:0] gpu_rsp_rdata;
    logic        l2_req_valid, l2_req_we;
    logic [31:0] l2_req_addr, l2_req_wdata;
    logic        l2_rsp_valid;
    logic [31:0] l2_rsp_rdata;
`ifdef L2_ARB_PERF_CNT_EN
    logic        perf_clr = 1'b0;
    logic [31:0] cpu_grant_cnt, gpu_grant_cnt, cpu_stall_cnt, gpu_stall_cnt;
`endif

    l2_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
        .cpu_req_we(cpu_req_we), .cpu_req_wdata(cpu_req_wdata), .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
        .gpu_req_valid(gpu_req_valid), .gpu_req_ready(gpu_req_ready), .gpu_req_addr(gpu_req_addr),
        .gpu_req_we(gpu_req_we), .gpu_req_wdata(gpu_req_wdata), .gpu_rsp_valid(gpu_rsp_valid),
        .gpu_rsp_rdata(gpu_rsp_rdata), .gpu_rsp_err(gpu_rsp_err),
        .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_we(l2_req_we),
        .l2_req_wdata(l2_req_wdata), .l2_rsp_valid(l2_rsp_valid), .l2_rsp_rdata(l2_rsp_rdata)
`ifdef L2_ARB_PERF_CNT_EN
        , .perf_clr(perf_clr), .cpu_grant_cnt(cpu_grant_cnt), .gpu_grant_cnt(gpu_grant_cnt),
        .cpu_stall_cnt(cpu_stall_cnt), .gpu_stall_cnt(gpu_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          gpu;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0;
    int cyc = 0;
    int inj_cyc = -1;
    int l2_lat = 1;
    bit l2_silent = 1'b0;
    bit l2_fixed_en = 1'b0;
    logic [31:0] l2_fixed = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] l2f(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    // L2 model: responds l2_lat cycles after seeing the request pulse, or never when silent.
    initial begin
        int cd = 0;
        logic [31:0] a = '0;
        l2_rsp_valid = 1'b0;
        l2_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            l2_rsp_valid = 1'b0;
            l2_rsp_rdata = '0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    l2_rsp_valid = 1'b1;
                    l2_rsp_rdata = l2_fixed_en ? l2_fixed : l2f(a);
                end
            end
            if (cyc == inj_cyc) begin
                l2_rsp_valid = 1'b1;
                l2_rsp_rdata = 32'h0000_0BAD;
            end
            if (l2_req_valid && !l2_silent) begin
                cd = l2_lat;
                a  = l2_req_addr;
            end
        end
    end

    // Response monitor: every response strobe must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cpu_rsp_valid || gpu_rsp_valid) begin
                chk("rsp_both", cpu_rsp_valid && gpu_rsp_valid, 0);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_owner", gpu_rsp_valid, e.gpu);
                    chk("rsp_rdata", gpu_rsp_valid ? gpu_rsp_rdata : cpu_rsp_rdata, e.rdata);
                    chk("rsp_err", gpu_rsp_valid ? gpu_rsp_err : cpu_rsp_err, e.err);
                end
            end
        end
    end

    task automatic wait_rsp(input string tag, input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(cpu_rsp_valid || gpu_rsp_valid) && n < lim);
        chk(tag, cpu_rsp_valid || gpu_rsp_valid, 1);
    endtask

    task automatic xact(input bit g, input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        if (g) begin gpu_req_valid = 1'b1; gpu_req_addr = a; gpu_req_we = 1'b0; end
        else   begin cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_we = 1'b0; end
        #1;
        while (!(g ? gpu_req_ready : cpu_req_ready) && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("xact_acc", g ? gpu_req_ready : cpu_req_ready, 1);
        exp_q.push_back('{g, l2f(a), 1'b0});
        @(negedge clk);
        cpu_req_valid = 1'b0;
        gpu_req_valid = 1'b0;
        wait_rsp("xact_rsp", 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        bit exp_seq [4];
        int grants, last_i, n;
        logic [31:0] a_cpu, a_gpu;
        bit own;
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_l2_vld", l2_req_valid, 0);
        chk("rst_l2_addr", l2_req_addr, 0);
        chk("rst_rsp", {cpu_rsp_valid, gpu_rsp_valid, cpu_rsp_err, gpu_rsp_err}, 0);
        chk("rst_ready", {cpu_req_ready, gpu_req_ready}, 0);
        @(negedge clk);
        rst = 1'b0;

        // CPU read, L2 hit
        l2_fixed_en = 1'b1;
        l2_fixed    = 32'hDEAD_BEEF;
        l2_lat      = 1;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h40; cpu_req_we = 1'b0;
        #1;
        chk("t1_ready", cpu_req_ready, 1);
        chk("t1_l2vld_T", l2_req_valid, 0);
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
        @(negedge clk);
        cpu_req_valid = 1'b0;
        #1;
        chk("t1_l2vld_T1", l2_req_valid, 1);
        chk("t1_l2addr", l2_req_addr, 32'h40);
        chk("t1_l2we", l2_req_we, 0);
        @(negedge clk);
        #1;
        chk("t1_l2vld_T2", l2_req_valid, 0);
        chk("t1_cpu_rsp_T2", cpu_rsp_valid, 1);
        chk("t1_gpu_rsp", gpu_rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("t1_rsp_once", cpu_rsp_valid, 0);
        l2_fixed_en = 1'b0;

        // both requesters valid continuously from reset
        rst = 1'b1;
        @(negedge clk);
        grants = 0; last_i = 0;
        a_cpu = 32'h1000; a_gpu = 32'h2000;
        for (int i = 0; i < 30 && grants < 4; i++) begin
            @(negedge clk);
            rst = 1'b0;
            cpu_req_valid = 1'b1; cpu_req_addr = a_cpu;
            gpu_req_valid = 1'b1; gpu_req_addr = a_gpu;
            #1;
`ifdef L2_ARB_PERF_CNT_EN
            if (grants == 2 && i == last_i + 1) begin
                chk("t2_cpu_stall", cpu_stall_cnt, 3);
                chk("t2_gpu_stall", gpu_stall_cnt, 3);
            end
`endif
            if (cpu_req_ready || gpu_req_ready) begin
                own = gpu_req_ready;
                chk("t2_rr_owner", own, exp_seq[grants]);
                if (grants > 0) chk("t2_rr_gap", i - last_i, 3);
                exp_q.push_back('{exp_seq[grants], l2f(exp_seq[grants] ? a_gpu : a_cpu), 1'b0});
                if (own) a_gpu = a_gpu + 4; else a_cpu = a_cpu + 4;
                last_i = i;
                grants++;
            end
        end
        chk("t2_grants", grants, 4);
        @(negedge clk);
        cpu_req_valid = 1'b0; gpu_req_valid = 1'b0;
        repeat (3) @(negedge clk);

        // GPU write with a 10-cycle miss while the CPU waits
        l2_lat = 10;
        @(negedge clk);
        gpu_req_valid = 1'b1; gpu_req_addr = 32'h100; gpu_req_we = 1'b1; gpu_req_wdata = 32'h5A5A_5A5A;
        #1;
        chk("t3_gpu_ready", gpu_req_ready, 1);
        exp_q.push_back('{1'b1, l2f(32'h100), 1'b0});
        @(negedge clk);
        gpu_req_valid = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h200; cpu_req_we = 1'b0;
        #1;
        chk("t3_l2vld", l2_req_valid, 1);
        l2_lat = 1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            chk("t3_cpu_ready", cpu_req_ready, 0);
            chk("t3_hold", {l2_req_addr, l2_req_we, l2_req_wdata[30:0]}, {32'h100, 1'b1, 31'h5A5A_5A5A});
            chk("t3_no_pulse", l2_req_valid, 0);
        end while (!gpu_rsp_valid && n < 20);
        chk("t3_miss_len", n, 10);
        @(negedge clk);
        #1;
        chk("t3_cpu_next", cpu_req_ready, 1);
        exp_q.push_back('{1'b0, l2f(32'h200), 1'b0});
        @(negedge clk);
        cpu_req_valid = 1'b0;
        wait_rsp("t3_cpu_rsp", 6);

        // timeout with a silent L2
        l2_silent = 1'b1;
        @(negedge clk);
        gpu_req_valid = 1'b1; gpu_req_addr = 32'h300; gpu_req_we = 1'b0;
        #1;
        chk("t4_ready", gpu_req_ready, 1);
        exp_q.push_back('{1'b1, 32'h0, 1'b1});
        @(negedge clk);
        gpu_req_valid = 1'b0;
        #1;
        n = 1;
        while (!gpu_rsp_valid && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t4_to_cycle", n, 17);
        chk("t4_rdata0", gpu_rsp_rdata, 0);
        inj_cyc   = cyc + 1;
        l2_silent = 1'b0;
        l2_lat    = 1;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h400;
        #1;
        chk("t4_stale_cpu", cpu_rsp_valid, 0);
        chk("t4_stale_gpu", gpu_rsp_valid, 0);
        chk("t4_cpu_acc", cpu_req_ready, 1);
        exp_q.push_back('{1'b0, l2f(32'h400), 1'b0});
        @(negedge clk);
        cpu_req_valid = 1'b0;
        wait_rsp("t4_cpu_rsp", 6);

        // reset while waiting on a miss
        l2_lat = 10;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h500; cpu_req_we = 1'b1; cpu_req_wdata = 32'h1234_5678;
        #1;
        chk("t5_ready", cpu_req_ready, 1);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_l2_vld", l2_req_valid, 0);
        chk("t5_l2_fields", {l2_req_addr, l2_req_we, l2_req_wdata}, 0);
        chk("t5_rsp", {cpu_rsp_valid, gpu_rsp_valid, cpu_rsp_err, gpu_rsp_err}, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (l2_rsp_valid) chk("t5_stale", cpu_rsp_valid || gpu_rsp_valid, 0);
        end
        l2_lat = 1;

`ifdef L2_ARB_PERF_CNT_EN
        // grant counters and clear
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        xact(1'b0, 32'h600);
        xact(1'b1, 32'h700);
        xact(1'b0, 32'h604);
        xact(1'b1, 32'h704);
        xact(1'b0, 32'h608);
        @(negedge clk);
        #1;
        chk("t6_cpu_grants", cpu_grant_cnt, 3);
        chk("t6_gpu_grants", gpu_grant_cnt, 2);
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        #1;
        chk("t6_clr", {cpu_grant_cnt, gpu_grant_cnt}, 0);
        chk("t6_clr_stall", {cpu_stall_cnt, gpu_stall_cnt}, 0);
`else
        xact(1'b0, 32'h600);
        xact(1'b1, 32'h700);
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
